issue_scoreboard: RTL
=====================

# issue_scoreboard

Issue controller between the instruction fetch unit and `data_fetch`. It accepts instructions over a valid/ready handshake and tracks the destination register of every in-flight instruction in a fixed-depth scoreboard. It holds back any instruction that reads a register still being produced. It also sequences run start, halt, and pipeline drain.

## Interface
- `INSTRW`, 32: instruction width; fields are func[31:27], res[26:18], op0[17:9], op1[8:0].
- `FUNCW`, 5: func field width.
- `ADDRW`, 9: register address width.
- `DEPTH`, 8: cycles a destination stays in flight (data fetch plus execute plus writeback); range 2..16.
- `FUNC_CVT`, 5'h0A: func code whose first source is the res field.
- `FUNC_ICV`, 5'h0B: func code whose first source is the res field.
- `HALT_INSTR`, 32'hFFFF_FFFF: halt encoding.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; begins a run.
- `in_valid` in 1: fetch presents an instruction.
- `in_instr` in INSTRW: instruction from fetch.
- `in_ready` out 1: the instruction is accepted this cycle.
- `out_valid` out 1: drives `data_fetch` ins_valid.
- `out_instr` out INSTRW: drives `data_fetch` instr.
- `busy` out 1: state is RUN or DRAIN.
- `done` out 1: sticky; the run has drained after halt.
- `stall_cnt` out 16: hazard stall cycles.
- `issue_cnt` out 16: instructions issued.

## Operation
- States:
  - IDLE, the reset state.
  - RUN.
  - DRAIN.
  - DONE.
- State transitions:
  - IDLE -> RUN on `start`.
  - RUN -> DRAIN when the halt instruction is accepted.
  - DRAIN -> DONE when the scoreboard is empty and `out_valid` is 0.
  - DONE -> RUN on `start`.
  - `start` in RUN or DRAIN is ignored.
- On entering RUN from `start`:
  - `done` is cleared.
  - Both counters are cleared.
- Scoreboard: DEPTH entries of {v, addr}, shifted by one every cycle.
  - Entry 0 loads {1, res} when a non-NOP, non-halt instruction is accepted; otherwise it loads {0, 0}.
  - The entry leaving position DEPTH-1 is discarded.
- Sources of the presented instruction:
  - src0 = res if func is FUNC_CVT or FUNC_ICV; otherwise src0 = op0.
  - src1 = op1.
- Hazard = any valid entry with addr == src0 or addr == src1.
  - Hazard is forced to 0 for NOP (func == 0) and for the halt instruction.
  - No WAW check: the fixed latency guarantees in-order writeback.
- `in_ready` = (state == RUN) && !hazard.
- Accept = `in_valid` && `in_ready`.
  - Fetch must hold `in_instr` stable while `in_valid` && !`in_ready`.
- NOP is accepted and forwarded unchanged, without a scoreboard entry.
- Halt is forwarded on `out_instr`, so `data_fetch` sees it, and then the state moves to DRAIN. `in_ready` is 0 in DRAIN, DONE, and IDLE.
- `stall_cnt` increments in every RUN cycle with `in_valid` && hazard.
- `issue_cnt` increments on every accept, including NOP and halt.
- Both counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - State: IDLE.
  - Scoreboard: all entries {0, 0}.
  - `in_ready`: 0.
  - `out_valid`: 0.
  - `out_instr`: 0.
  - `busy`: 0.
  - `done`: 0.
  - `stall_cnt`: 0.
  - `issue_cnt`: 0.
- Reset mid-run clears all of the above immediately. In-flight entries are lost; the next run starts from an empty scoreboard.
- `out_valid`/`out_instr` are registered:
  - An accept at edge k gives `out_valid` = 1 in cycle k+1 only.
  - With no accept, `out_valid` = 0 and `out_instr` = 0.
- An entry written at edge k occupies entries 0..DEPTH-1 during cycles k+1..k+DEPTH.
- Dependent pair: consumer `out_valid` is at least DEPTH+1 cycles after producer `out_valid`. Independent instructions issue back-to-back, one per cycle.
- The hazard check is combinational on the current scoreboard contents. There is no bypass of the entry being written this cycle, which is safe because that entry appears at the same edge as the accept.
- Timing of `start`:
  - `start` in cycle c puts the state in RUN, so `in_ready` can be 1, from cycle c+1.
  - `start` simultaneous with reset deassertion is ignored.
- DONE timing:
  - DONE, and `done` = 1, is reached at the first edge where the scoreboard is empty and `out_valid` = 0.
  - This is at most DEPTH+1 cycles after the halt accept.
- `busy` = 1 in RUN and DRAIN.

## Configuration
- `ISSUE_SCB_PERF_EN`:
  - Defined: `stall_cnt` and `issue_cnt` are implemented as specified.
  - Undefined: no counter registers; both ports are tied to 16'h0.
  - Issue behaviour is identical either way.

## Test plan
- Reset then `start`, 4 independent instructions on consecutive cycles -> `out_valid` on 4 consecutive cycles, `stall_cnt` = 0, `issue_cnt` = 4.
- DEPTH = 8: producer res = 9'd5, followed at once by a consumer with op1 = 5 -> consumer `out_valid` 9 cycles after the producer, `stall_cnt` = 8.
- FUNC_CVT instruction with res = 7 following a producer of r7 -> stalled 8 cycles. The same instruction with op0 = 7 and res ≠ 7 -> no stall.
- NOP (func 0) with op0 = op1 = in-flight address -> accepted immediately, no scoreboard entry.
- Halt accepted -> halt forwarded on `out_instr`, `in_ready` = 0 afterwards, `done` = 1 at most DEPTH+1 cycles later. A second `start` -> RUN, counters cleared.
- `rst_n` low for one cycle with 3 entries in flight -> all outputs 0, state IDLE. After `start`, a formerly dependent instruction issues without stall.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Issue controller: a fixed-latency RAW scoreboard behind a valid/ready intake, plus run/halt/drain sequencing.
// Build option ISSUE_SCB_PERF_EN adds saturating stall/issue counters; without it both count ports read 0.
module issue_scoreboard #(
  parameter int unsigned       INSTRW     = 32,
  parameter int unsigned       FUNCW      = 5,
  parameter int unsigned       ADDRW      = 9,
  parameter int unsigned       DEPTH      = 8,
  parameter logic [FUNCW-1:0]  FUNC_CVT   = 5'h0A,
  parameter logic [FUNCW-1:0]  FUNC_ICV   = 5'h0B,
  parameter logic [INSTRW-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [INSTRW-1:0] in_instr,
  output logic              in_ready,
  output logic              out_valid,
  output logic [INSTRW-1:0] out_instr,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       issue_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e state_q, state_d;

  logic [FUNCW-1:0] func;
  logic [ADDRW-1:0] res, op0, op1, src0, src1;
  logic             is_nop, is_halt, hazard, accept, sb_load;

  assign func    = in_instr[INSTRW-1 -: FUNCW];
  assign res     = in_instr[2*ADDRW +: ADDRW];
  assign op0     = in_instr[ADDRW +: ADDRW];
  assign op1     = in_instr[0 +: ADDRW];
  assign is_nop  = (func == '0);
  assign is_halt = (in_instr == HALT_INSTR);
  assign src0    = (func == FUNC_CVT || func == FUNC_ICV) ? res : op0;
  assign src1    = op1;

  // Scoreboard: one slot per cycle of producer latency, shifted every cycle
  logic [DEPTH-1:0]            vld_pipe_q, vld_pipe_d;
  logic [DEPTH-1:0][ADDRW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]            hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign hit[i] = vld_pipe_q[i] && (addr_q[i] == src0 || addr_q[i] == src1);
  end

  // Only RAW matters; the fixed latency keeps writeback in order
  assign hazard   = (|hit) && !is_nop && !is_halt;
  assign in_ready = (state_q == RUN) && !hazard;
  assign accept   = in_valid && in_ready;
  assign sb_load  = accept && !is_nop && !is_halt;

  assign vld_pipe_d = {vld_pipe_q[DEPTH-2:0], sb_load};
  assign addr_d     = {addr_q[DEPTH-2:0], (sb_load ? res : {ADDRW{1'b0}})};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vld_pipe_q <= '0;
      addr_q     <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
    end else begin
      state_q    <= state_d;
      vld_pipe_q <= vld_pipe_d;
      addr_q     <= addr_d;
      out_valid  <= accept;
      out_instr  <= accept ? in_instr : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && is_halt) state_d = DRAIN;
      DRAIN:   if (!(|vld_pipe_q) && !out_valid) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

`ifdef ISSUE_SCB_PERF_EN
  logic [15:0] stall_q, stall_d, issue_q, issue_d;
  logic        clr_cnt;

  assign clr_cnt = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    stall_d = stall_q;
    issue_d = issue_q;
    if (clr_cnt) begin
      stall_d = '0;
      issue_d = '0;
    end else begin
      if (state_q == RUN && in_valid && hazard && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
      if (accept && issue_q != 16'hFFFF) issue_d = issue_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      issue_q <= '0;
    end else begin
      stall_q <= stall_d;
      issue_q <= issue_d;
    end
  end

  assign stall_cnt = stall_q;
  assign issue_cnt = issue_q;
`else
  assign stall_cnt = 16'h0;
  assign issue_cnt = 16'h0;
`endif

endmodule
